// File: rtl/recv_pkg.sv
// Shared UART definitions: data width, 3-bit receiver state encodings and
// the oversample divider calculation.
package recv_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAITHI = 3'd5;

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int calc_div(input int clock, input int baud, input int os);
        int d;
        d = clock / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/recv_brg.sv
// Oversample tick generator for the UART receiver. A down-counter reloads
// on terminal count; restart realigns the tick phase to a start edge.
module recv_brg
    import recv_pkg::*;
#(
    parameter int DIV = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counts down to zero, then reloads; restart forces a full period.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/recv.sv
// UART receiver, 8 data bits, LSB first, 1 stop bit, oversampled.
// Optional even-parity bit enabled by defining RECV_PARITY_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line high, waiting for a synchronized falling edge
// START     | counting to the start-bit midpoint to reject glitches
// DATA      | sampling 8 data bits at each bit midpoint
// PARITY    | sampling the even-parity bit (RECV_PARITY_EN only)
// STOP      | checking the stop bit, issuing valid/frame_err/parity_err
// WAITHI    | after a bad stop, waiting for the line to return high
module recv
    import recv_pkg::*;
#(
    parameter int BAUD       = 115200,
    parameter int CLOCK      = 12_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int DIV   = calc_div(CLOCK, BAUD, OVERSAMPLE);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              fall;
    logic              tick;
    logic              restart;
    logic              sample;
    logic [2:0]        state;
    logic [CNT_W-1:0]  os_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
`ifdef RECV_PARITY_EN
    logic              par_bad;
    logic              parity_err_q;
`endif

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall    = rx_prev && !rx_sync;
    assign restart = (state == ST_IDLE) && fall;
    assign sample  = tick && (os_cnt == '0);

    recv_brg #(
        .DIV (DIV)
    ) u_brg (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Frame sequencing: midpoint sampling, shifting and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef RECV_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef RECV_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Tick counter runs down between midpoints; reloaded on each sample.
            if (tick && (os_cnt != '0)) begin
                os_cnt <= os_cnt - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state  <= ST_START;
                        os_cnt <= HALF_M1;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (!rx_sync) begin
                            state   <= ST_DATA;
                            busy    <= 1'b1;
                            os_cnt  <= FULL_M1;
                            bit_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shreg   <= {rx_sync, shreg[DATA_W-1:1]};
                        os_cnt  <= FULL_M1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef RECV_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef RECV_PARITY_EN
                ST_PARITY: begin
                    if (sample) begin
                        par_bad <= (^shreg) ^ rx_sync;
                        os_cnt  <= FULL_M1;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (sample) begin
                        busy <= 1'b0;
                        if (rx_sync) begin
                            state <= ST_IDLE;
`ifdef RECV_PARITY_EN
                            if (par_bad) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                valid <= 1'b1;
                                data  <= shreg;
                            end
`else
                            valid <= 1'b1;
                            data  <= shreg;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAITHI;
                        end
                    end
                end
                ST_WAITHI: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RECV_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_recv.sv
// Self-checking bench for the UART receiver: table-driven frames, hand
// sequences for glitch / reset / back-to-back cases, and random frames
// checked against a frame-level expectation model.
module tb_recv;

    localparam int CLOCK = 12_000_000;
    localparam int BAUD  = 115200;
    localparam int OS    = 16;
    localparam int DIV   = CLOCK / (BAUD * OS);
    localparam int BIT   = DIV * OS;

`ifdef RECV_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         hold;
        int         kind;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int n_checks = 0;
    int n_err    = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    int excl_viol = 0;
    int wide_viol = 0;
    bit busy_seen = 1'b0;
    logic pv = 1'b0;
    logic pf = 1'b0;
    logic pp = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] mdata;

    recv #(
        .BAUD       (BAUD),
        .CLOCK      (CLOCK),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            got_q.push_back(data);
        end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol++;
        if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) wide_viol++;
        pv = valid;
        pf = frame_err;
        pp = parity_err;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outcome of one frame from its line-level content.
    function automatic int model_kind(input logic stop, input logic pflip);
        if (!stop) return K_FERR;
        if (PAR_EN && pflip) return K_PERR;
        return K_VALID;
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic pflip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ pflip);
        send_bit(stop);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic pflip,
                             input logic stop, input int hold, input int gap,
                             input int kind, input logic [7:0] exp_data);
        int v0, f0, p0;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        busy_seen = 1'b0;
        drive_frame(d, pflip, stop);
        chk({name, "_busy_in_frame"}, int'(busy_seen), 1);
        chk({name, "_busy_after_stop"}, int'(busy), 0);
        busy_seen = 1'b0;
        repeat (hold) @(posedge clk);
        #1 rx = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
        chk({name, "_busy_idle"}, int'(busy_seen), 0);
        chk({name, "_valid_cnt"}, n_valid - v0, (kind == K_VALID) ? 1 : 0);
        chk({name, "_ferr_cnt"}, n_ferr - f0, (kind == K_FERR) ? 1 : 0);
        chk({name, "_perr_cnt"}, n_perr - p0, (kind == K_PERR) ? 1 : 0);
        chk({name, "_data"}, int'(data), int'(exp_data));
    endtask

    initial begin
        vec_t tbl[6];
        int v0, f0, p0;
        logic [7:0] d;
        logic stop, pflip;
        int kind, hold, gap;

        tbl[0] = '{8'h55, 1'b1, 0,   K_VALID, 8'h55};
        tbl[1] = '{8'hA3, 1'b0, 300, K_FERR,  8'h55};
        tbl[2] = '{8'h00, 1'b1, 0,   K_VALID, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 0,   K_VALID, 8'hFF};
        tbl[4] = '{8'h80, 1'b0, 20,  K_FERR,  8'hFF};
        tbl[5] = '{8'h01, 1'b1, 0,   K_VALID, 8'h01};

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].d, 1'b0, tbl[i].stop,
                      tbl[i].hold, BIT, tbl[i].kind, tbl[i].exp_data);
        end
        mdata = 8'h01;

        // Short glitch on idle line
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        chk("glitch_busy", int'(busy_seen), 0);
        chk("glitch_strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
        run_frame("after_glitch", 8'h5A, 1'b0, 1'b1, 0, BIT, K_VALID, 8'h5A);

        // Back-to-back 0x30..0x39
        got_q.delete();
        v0 = n_valid; f0 = n_ferr;
        for (int i = 0; i < 10; i++) drive_frame(8'h30 + 8'(i), 1'b0, 1'b1);
        repeat (BIT) @(posedge clk);
        #1;
        chk("b2b_valid_cnt", n_valid - v0, 10);
        chk("b2b_ferr_cnt", n_ferr - f0, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b2b_data%0d", i),
                (i < got_q.size()) ? int'(got_q[i]) : -1, 'h30 + i);
        end
        mdata = 8'h39;

        // Reset in the middle of 0x7E, then a clean 0x7E
        d = 8'h7E;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (BIT / 2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_data", int'(data), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frame_err", int'(frame_err), 0);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        chk("midrst_no_strobe", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
        run_frame("after_rst", 8'h7E, 1'b0, 1'b1, 0, BIT, K_VALID, 8'h7E);
        mdata = 8'h7E;

`ifdef RECV_PARITY_EN
        // 0x31 has three ones, so the even-parity bit must be 1
        run_frame("par_bad", 8'h31, 1'b1, 1'b1, 0, BIT, K_PERR, mdata);
        run_frame("par_good", 8'h31, 1'b0, 1'b1, 0, BIT, K_VALID, 8'h31);
        run_frame("par_bad_stop", 8'hC4, 1'b1, 1'b0, 40, BIT, K_FERR, 8'h31);
        mdata = 8'h31;
`endif

        // Random frames against the model
        for (int i = 0; i < 16; i++) begin
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 7) != 0);
            pflip = PAR_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
            hold  = stop ? 0 : int'($urandom_range(0, 60));
            gap   = stop ? int'($urandom_range(0, BIT)) : int'($urandom_range(8, BIT));
            kind  = model_kind(stop, pflip);
            if (kind == K_VALID) mdata = d;
            run_frame($sformatf("rnd%0d", i), d, pflip, stop, hold, gap, kind, mdata);
        end

        chk("strobe_exclusive", excl_viol, 0);
        chk("strobe_width", wide_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/recv.md
RECV -- requirements
Module: recv

Interface
REQ-001 Parameter BAUD, default 115200, serial bit rate in bits/s, SHALL be provided.
REQ-002 Parameter CLOCK, default 12_000_000, clk frequency in Hz, SHALL be provided.
REQ-003 Parameter OVERSAMPLE, default 16, sample ticks per bit, SHALL be provided; legal values are even and at least 4.
REQ-004 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 data  output  8  last correctly received byte.
REQ-008 valid  output  1  one-cycle strobe; data updated in the same cycle.
REQ-009 busy  output  1  high from a confirmed start bit until the frame ends.
REQ-010 frame_err  output  1  one-cycle strobe on a bad stop bit.
REQ-011 parity_err  output  1  one-cycle strobe on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-013 Tick divider SHALL be CLOCK/(BAUD*OVERSAMPLE), integer-truncated, minimum 1.
REQ-014 The divider and the tick counter SHALL restart on the cycle a falling edge is detected in IDLE.
REQ-015 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP and WAITHI.
REQ-016 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-017 START SHALL resample at tick OVERSAMPLE/2-1: low->DATA and busy=1; high->IDLE as a glitch, with no strobe.
REQ-018 DATA SHALL sample every OVERSAMPLE ticks after the midpoint, shifting LSB first, 8 bits (3-bit counter, exits at 7).
REQ-019 At the STOP midpoint, high SHALL pulse valid and load data; low SHALL pulse frame_err, leave data unchanged, and enter WAITHI.
REQ-020 WAITHI SHALL hold until synchronized rx=1, then go to IDLE; no start detection SHALL occur in WAITHI.
REQ-021 On a good stop, busy SHALL drop in the strobe cycle and the state SHALL return to IDLE, so a start edge half a bit later is accepted.
REQ-022 valid, frame_err and parity_err SHALL be mutually exclusive and never wider than 1 cycle.
REQ-023 There is no consumer handshake; a new frame SHALL overwrite data, and no overrun SHALL be flagged.

Reset
REQ-024 reset SHALL force IDLE; data=0, valid=0, busy=0, frame_err=0, parity_err=0; the synchronizer SHALL load 1s.
REQ-025 reset mid-frame SHALL abandon the frame without a strobe; reception SHALL resume on the first falling edge after reset deasserts.

Configuration
REQ-026 With RECV_PARITY_EN defined, a PARITY state SHALL follow DATA and sample one even-parity bit.
REQ-027 On a parity mismatch, parity_err SHALL pulse at the STOP midpoint in place of valid, data SHALL be unchanged, and the stop check SHALL still apply; frame_err takes priority.
REQ-028 Without RECV_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be constant 0.

Structure
REQ-029 State encodings (3-bit) and the data-width constant 8 SHALL live in the shared UART package/include used by the transmitter side.
REQ-030 One sub-module, recv_brg, SHALL provide the oversample tick generator with a synchronous restart input; all other logic SHALL be in recv.

Verification (CLOCK=12_000_000, BAUD=115200, OVERSAMPLE=16 -> divider 6, bit = 96 clk)
REQ-031 8N1 frame 0x55 -> exactly one valid pulse, data=0x55, busy low after the stop midpoint, frame_err=0.
REQ-032 Frame 0xA3 with low stop bit, held low for 300 clk -> one frame_err pulse, valid=0, data keeps its previous value, no new start until rx high.
REQ-033 30-clk low glitch on idle rx -> busy never asserts, no strobes, state returns to IDLE.
REQ-034 Back-to-back 0x30..0x39 with 1 stop bit -> ten valid pulses, data in order, no frame_err.
REQ-035 reset pulsed at bit 4 of 0x7E, then a full 0x7E frame -> outputs 0 the cycle after reset, then a single valid with data=0x7E.
REQ-036 RECV_PARITY_EN, 0x31 sent with parity bit 0 -> parity_err pulse, valid=0; with parity bit 1 -> valid, data=0x31.
